// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Two-stage pipelined bitwise logic unit. This module takes a beat of two
// WIDTH-bit operands and a 3-bit function select. Two register stages later it
// presents the bitwise result, a zero flag and a parity flag. Both sides use
// valid/ready flow control. A wrapping counter records how many results the
// consumer has taken.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high reset
//   in_valid    in   1      operand beat valid
//   in_ready    out  1      unit can accept an operand beat this cycle
//   in_a        in   WIDTH  operand A
//   in_b        in   WIDTH  operand B (unused by NOT A and PASS A)
//   in_op       in   3      function select:
//                             0 AND, 1 OR, 2 NOT A, 3 NAND,
//                             4 NOR, 5 XOR, 6 XNOR, 7 PASS A
//   out_valid   out  1      result beat valid
//   out_ready   in   1      consumer accepts the result beat
//   out_result  out  WIDTH  function result
//   out_zero    out  1      1 when out_result == 0
//   out_parity  out  1      XOR-reduction of out_result
//   done_count  out  CNT_W  number of results taken (wraps to 0)
//
// Handshake: a beat moves across an interface on every rising edge where both
// valid and ready are high. While valid is high and ready is low, the producer
// keeps the beat and its payload stable. Valid never depends on ready. Ready
// may depend combinationally on the downstream ready.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_parity;

  // ---------------------------------------------------------------------------
  // Flow control
  // A stage may load when it is empty, or when the stage after it is being
  // drained on this same edge. Because of this ready chain, a full pipeline
  // with out_ready high still accepts one beat per cycle.
  // ---------------------------------------------------------------------------
  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_fire  = in_valid && s1_adv;
    out_fire = s2_valid && out_ready;
  end

  assign in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: capture operands and function select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // Payload loads only on an accepted beat. When the stage is idle the old
  // contents are don't-care, so they can stay as they are.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_a  <= in_a;
      s1_b  <= in_b;
      s1_op <= op_e'(in_op);
    end
  end

  // ---------------------------------------------------------------------------
  // Function evaluation between stage 1 and stage 2
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] fn_result;

  always_comb begin
    fn_result = '0;
    case (s1_op)
      OP_AND:  fn_result = s1_a & s1_b;
      OP_OR:   fn_result = s1_a | s1_b;
      OP_NOTA: fn_result = ~s1_a;
      OP_NAND: fn_result = ~(s1_a & s1_b);
      OP_NOR:  fn_result = ~(s1_a | s1_b);
      OP_XOR:  fn_result = s1_a ^ s1_b;
      OP_XNOR: fn_result = ~(s1_a ^ s1_b);
      OP_PASS: fn_result = s1_a;
      default: fn_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2: result and flags, driven straight to the output ports.
  // Reset clears the payload too, so the outputs read as all zero right after
  // reset. This includes out_zero, even though out_result is 0 at that point.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_parity <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= fn_result;
        s2_zero   <= (fn_result == '0);
        s2_parity <= ^fn_result;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_zero   = s2_zero;
  assign out_parity = s2_parity;

  // ---------------------------------------------------------------------------
  // Completed-result counter, wraps naturally at 2^CNT_W
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      done_count <= '0;
    end else if (out_fire) begin
      done_count <= done_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Testbench for logic_unit_pipe, using a 4-bit counter so the wrap is easy to
// reach. A transaction-level model is checked on every falling edge. The model
// holds a queue of accepted-but-not-yet-delivered results, each tagged with the
// edge at which it was accepted. From that queue it derives:
//   out_valid - a beat is pending and was not accepted on the latest edge
//   in_ready  - fewer than two beats in flight, or the consumer is ready
// Directed sections also compare captured outputs against hand-computed
// literals.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_parity;
  logic [CNT_W-1:0] done_count;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .done_count (done_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q[$];
  int               stamp_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic             got_z[$];
  logic             got_p[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               edge_cnt = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  bit               chk_en = 0;
  bit               after_rst = 0;
  bit               prev_stall = 0;
  logic [WIDTH-1:0] held_res;
  logic             held_z;
  logic             held_p;
  int               acc_cnt = 0;
  bit               rnd_on = 0;

  logic [WIDTH-1:0] t1_exp [0:7] = '{8'h30, 8'hFC, 8'h0F, 8'hCF,
                                     8'h03, 8'hCC, 8'h33, 8'hF0};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Function table written straight from the opcode list
  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: check current outputs, then advance the model for the
  // coming rising edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    bit exp_valid;
    bit exp_ready;
    exp_valid = (exp_q.size() > 0) && (stamp_q[0] != edge_cnt);
    exp_ready = (exp_q.size() < 2) || out_ready;
    if (chk_en) begin
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, exp_ready);
      check("done_count", done_count, cnt_model);
      if (exp_valid && out_valid) begin
        check("out_result", out_result, exp_q[0]);
        check("out_zero", out_zero, exp_q[0] == '0);
        check("out_parity", out_parity, ^exp_q[0]);
      end else if (after_rst) begin
        check("reset_result", out_result, 0);
        check("reset_zero", out_zero, 0);
        check("reset_parity", out_parity, 0);
      end
      if (prev_stall) begin
        check("stall_result", out_result, held_res);
        check("stall_zero", out_zero, held_z);
        check("stall_parity", out_parity, held_p);
      end
    end
    if (chk_en && !reset && out_valid && out_ready) begin
      got_q.push_back(out_result);
      got_z.push_back(out_zero);
      got_p.push_back(out_parity);
    end
    if (chk_en && !reset && in_valid && in_ready) acc_cnt++;

    prev_stall = 0;
    if (reset) begin
      exp_q.delete();
      stamp_q.delete();
      cnt_model = '0;
      after_rst = 1;
      chk_en    = 1;
    end else if (chk_en) begin
      if (exp_valid) after_rst = 0;
      if (exp_valid && !out_ready) begin
        prev_stall = 1;
        held_res   = out_result;
        held_z     = out_zero;
        held_p     = out_parity;
      end
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
        cnt_model = cnt_model + 1'b1;
      end
      if (in_valid && exp_ready) begin
        exp_q.push_back(ref_op(in_a, in_b, in_op));
        stamp_q.push_back(edge_cnt + 1);
      end
    end
    edge_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [2:0] op);
    int k;
    bit ok;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    k  = 0;
    ok = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    check("send_accepted", ok, 1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", exp_q.size() == 0, 1);
  endtask

  task automatic clear_got();
    got_q.delete();
    got_z.delete();
    got_p.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    do_reset();
    tick();

    // Eight functions on one operand pair, streamed back to back
    clear_got();
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) send(8'hF0, 8'h3C, op[2:0]);
    in_valid = 1'b0;
    drain(50);
    check("t1_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check($sformatf("t1_result%0d", i), got_q[i], t1_exp[i]);
    check("t1_done_count", done_count, 8);

    // Flag cases
    clear_got();
    send(8'hAA, 8'hAA, 3'd5);
    send(8'h01, 8'h55, 3'd7);
    in_valid = 1'b0;
    drain(50);
    check("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_xor_result", got_q[0], 8'h00);
      check("t2_xor_zero", got_z[0], 1);
      check("t2_xor_parity", got_p[0], 0);
      check("t2_pass_result", got_q[1], 8'h01);
      check("t2_pass_zero", got_z[1], 0);
      check("t2_pass_parity", got_p[1], 1);
    end

    // Backpressure: five cycles with out_ready low and a beat always offered
    clear_got();
    acc_cnt   = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_b      = 8'h00;
    in_op     = 3'd7;
    for (int i = 0; i < 5; i++) begin
      in_a = 8'h10 + 8'(acc_cnt);
      tick();
    end
    check("t3_accepted", acc_cnt, 2);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_held_result", out_result, 8'h10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(50);
    check("t3_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t3_first", got_q[0], 8'h10);
      check("t3_second", got_q[1], 8'h11);
    end

    // Random valid / ready traffic against the model
    clear_got();
    rnd_on = 1;
    fork
      while (rnd_on) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    join_none
    for (int i = 0; i < 3000; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    rnd_on   = 0;
    tick();
    tick();
    out_ready = 1'b1;
    drain(50);
    check("t4_count", got_q.size(), 3000);

    // Counter wrap: 17 results on a 4-bit counter
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(8'(i * 7), 8'hA5, 3'(i % 8));
    in_valid = 1'b0;
    drain(50);
    check("t5_wrap", done_count, 1);

    // Reset with both stages full
    out_ready = 1'b0;
    send(8'h5A, 8'h0F, 3'd0);
    send(8'hC3, 8'h3C, 3'd1);
    in_valid = 1'b0;
    tick();
    check("t6_full_valid", out_valid, 1);
    check("t6_full_ready", in_ready, 0);
    clear_got();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_done_count", done_count, 0);
    check("t6_out_result", out_result, 0);
    out_ready = 1'b1;
    repeat (6) tick();
    check("t6_no_stale", got_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
